// File: rtl/led_chaser_master.sv
// LED chaser: periodically writes a rotating or counting 4-bit pattern to an Avalon-MM PIO slave.
// Define LED_CHASER_READBACK_EN to follow every write with a verifying read.
module led_chaser_master #(
   parameter int unsigned PERIOD_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       mode,
   output logic [1:0] avm_address,
   output logic       avm_chipselect,
   output logic       avm_write_n,
   output logic [3:0] avm_writedata,
   input  logic [3:0] avm_readdata,
   output logic [3:0] pattern,
   output logic       busy,
   output logic       readback_error
);

   localparam int unsigned TIMER_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(PERIOD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_WRITE = 2'd2,
      ST_READ  = 2'd3
   } state_t;

   state_t             state;
   logic [TIMER_W-1:0] timer;

   // Rotate a one-hot value left (repairing anything else to 0001), or count up modulo 16.
   function automatic logic [3:0] calc_next(input logic [3:0] p, input logic m);
      if (m)
         return p + 4'd1;
      if ((p != 4'd0) && ((p & (p - 4'd1)) == 4'd0))
         return {p[2:0], p[3]};
      return 4'b0001;
   endfunction

   // The PIO slave has a single register, so the address never moves off 0.
   assign avm_address = 2'd0;

`ifdef LED_CHASER_READBACK_EN
   logic rb_error;
   assign readback_error = rb_error;
`else
   logic readdata_unused;
   assign readdata_unused = ^avm_readdata;
   assign readback_error  = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         timer          <= '0;
         pattern        <= 4'b0001;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_writedata  <= 4'd0;
         busy           <= 1'b0;
`ifdef LED_CHASER_READBACK_EN
         rb_error       <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state <= ST_WAIT;
                  timer <= RELOAD;
               end
            end

            ST_WAIT: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (timer == '0) begin
                  state          <= ST_WRITE;
                  avm_chipselect <= 1'b1;
                  avm_write_n    <= 1'b0;
                  avm_writedata  <= calc_next(pattern, mode);
                  busy           <= 1'b1;
               end else begin
                  timer <= timer - TIMER_W'(1);
               end
            end

            ST_WRITE: begin
               pattern       <= avm_writedata;
               avm_write_n   <= 1'b1;
               avm_writedata <= 4'd0;
`ifdef LED_CHASER_READBACK_EN
               state <= ST_READ;
`else
               avm_chipselect <= 1'b0;
               busy           <= 1'b0;
               if (enable) begin
                  state <= ST_WAIT;
                  timer <= RELOAD;
               end else begin
                  state <= ST_IDLE;
               end
`endif
            end

            ST_READ: begin
`ifdef LED_CHASER_READBACK_EN
               // Sticky until reset: a single bad readback is enough to flag the slave.
               if (avm_readdata != pattern)
                  rb_error <= 1'b1;
`endif
               avm_chipselect <= 1'b0;
               busy           <= 1'b0;
               if (enable) begin
                  state <= ST_WAIT;
                  timer <= RELOAD;
               end else begin
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_chaser_master.sv
// Directed self-checking bench for led_chaser_master (PERIOD_CYCLES=4), both readback builds.
module tb_led_chaser_master;

   localparam int P = 4;
`ifdef LED_CHASER_READBACK_EN
   localparam int GAP = P + 2;
`else
   localparam int GAP = P + 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       mode = 1'b0;
   logic [1:0] avm_address;
   logic       avm_chipselect;
   logic       avm_write_n;
   logic [3:0] avm_writedata;
   logic [3:0] avm_readdata;
   logic [3:0] pattern;
   logic       busy;
   logic       readback_error;

   logic [3:0] slave_mem = 4'd0;
   logic       slave_bad = 1'b0;

   int total = 0;
   int bad = 0;

   led_chaser_master #(.PERIOD_CYCLES(P)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .pattern(pattern), .busy(busy),
      .readback_error(readback_error)
   );

   always #5 clk = ~clk;

   // PIO slave: stores writes, returns stored value (optionally corrupted in bit 0)
   always @(posedge clk)
      if (avm_chipselect && !avm_write_n) slave_mem <= avm_writedata;
   assign avm_readdata = slave_mem ^ {3'b000, slave_bad};

   task automatic wait_write(input int budget, output logic [3:0] data, output int cycles, output bit ok);
      ok = 1'b0; cycles = 0; data = 4'd0;
      while (!ok && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (avm_chipselect && !avm_write_n) begin
            ok = 1'b1;
            data = avm_writedata;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b0; mode = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (avm_chipselect !== 1'b0) begin bad++; $display("FAIL reset_cs: got %b want 0", avm_chipselect); end
      total++; if (avm_write_n !== 1'b1) begin bad++; $display("FAIL reset_wn: got %b want 1", avm_write_n); end
      total++; if (avm_address !== 2'd0) begin bad++; $display("FAIL reset_addr: got %h want 0", avm_address); end
      total++; if (avm_writedata !== 4'd0) begin bad++; $display("FAIL reset_wd: got %h want 0", avm_writedata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (pattern !== 4'b0001) begin bad++; $display("FAIL reset_pattern: got %b want 0001", pattern); end
      total++; if (readback_error !== 1'b0) begin bad++; $display("FAIL reset_rberr: got %b want 0", readback_error); end
      reset = 1'b0; enable = 1'b1;
   endtask

   task automatic test_rotate;
      logic [3:0] exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] d; int c; bit ok;
      for (int i = 0; i < 4; i++) begin
         wait_write(50, d, c, ok);
         total++; if (!ok) begin bad++; $display("FAIL rot_timeout%0d: got none want write", i); end
         total++; if (c !== ((i == 0) ? P + 1 : GAP)) begin bad++; $display("FAIL rot_gap%0d: got %0d want %0d", i, c, (i == 0) ? P + 1 : GAP); end
         total++; if (d !== exp[i]) begin bad++; $display("FAIL rot_data%0d: got %b want %b", i, d, exp[i]); end
         total++; if (avm_address !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL rot_addr_busy%0d: got %h/%b want 0/1", i, avm_address, busy); end
         if (i == 0) begin
            total++; if (pattern !== 4'b0001) begin bad++; $display("FAIL rot_pattern_inflight: got %b want 0001", pattern); end
         end
      end
      mode = 1'b1;
   endtask

   task automatic test_count;
      logic [3:0] d; int c; bit ok;
      for (int i = 2; i <= 16; i++) begin
         wait_write(50, d, c, ok);
         total++; if (!ok || d !== 4'(i)) begin bad++; $display("FAIL count_data%0d: got %h want %h", i, d, 4'(i)); end
      end
   endtask

   task automatic test_disable;
      logic [3:0] d; int c; bit ok; int cs_seen = 0;
      repeat (3) @(negedge clk);
      enable = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (avm_chipselect) cs_seen++;
      end
      total++; if (cs_seen !== 0) begin bad++; $display("FAIL dis_cs: got %0d want 0", cs_seen); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL dis_busy: got %b want 0", busy); end
      total++; if (pattern !== 4'h0) begin bad++; $display("FAIL dis_pattern: got %h want 0", pattern); end
      enable = 1'b1;
      wait_write(50, d, c, ok);
      total++; if (!ok || c !== P + 1) begin bad++; $display("FAIL dis_restart_lat: got %0d want %0d", c, P + 1); end
      total++; if (d !== 4'h1) begin bad++; $display("FAIL dis_restart_data: got %h want 1", d); end
   endtask

   task automatic test_readback;
      logic [3:0] d; int c; bit ok;
      slave_bad = 1'b1;
      wait_write(50, d, c, ok);
      @(negedge clk);
`ifdef LED_CHASER_READBACK_EN
      total++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rb_read_cycle: got cs=%b wn=%b busy=%b want 1/1/1", avm_chipselect, avm_write_n, busy); end
      @(negedge clk);
      total++; if (readback_error !== 1'b1) begin bad++; $display("FAIL rb_err_set: got %b want 1", readback_error); end
      slave_bad = 1'b0;
      repeat (2) wait_write(50, d, c, ok);
      repeat (3) @(negedge clk);
      total++; if (readback_error !== 1'b1) begin bad++; $display("FAIL rb_err_sticky: got %b want 1", readback_error); end
`else
      total++; if (avm_chipselect !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL norb_no_read: got cs=%b busy=%b want 0/0", avm_chipselect, busy); end
      slave_bad = 1'b0;
      repeat (2) wait_write(50, d, c, ok);
      total++; if (readback_error !== 1'b0) begin bad++; $display("FAIL norb_err: got %b want 0", readback_error); end
`endif
   endtask

   task automatic test_reset_midwrite;
      logic [3:0] d; int c; bit ok;
      wait_write(50, d, c, ok);
      total++; if (!ok) begin bad++; $display("FAIL mid_timeout: got none want write"); end
      #1 reset = 1'b1;
      #1;
      total++; if (avm_chipselect !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_cs: got cs=%b busy=%b want 0/0", avm_chipselect, busy); end
      total++; if (pattern !== 4'b0001) begin bad++; $display("FAIL mid_pattern: got %b want 0001", pattern); end
      total++; if (readback_error !== 1'b0) begin bad++; $display("FAIL mid_rberr: got %b want 0", readback_error); end
      mode = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [3:0] d; int c; bit ok; logic [3:0] exp = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         exp = {exp[2:0], exp[3]};
         wait_write(50, d, c, ok);
         total++; if (!ok || d !== exp) begin bad++; $display("FAIL b2b_data%0d: got %b want %b", i, d, exp); end
         total++; if (c !== ((i == 0) ? P + 1 : GAP)) begin bad++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, c, (i == 0) ? P + 1 : GAP); end
`ifdef LED_CHASER_READBACK_EN
         @(negedge clk);
         total++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b1 || avm_address !== 2'd0) begin bad++; $display("FAIL b2b_read%0d: got cs=%b wn=%b addr=%h want 1/1/0", i, avm_chipselect, avm_write_n, avm_address); end
         c = 1;
`endif
         total++; if (readback_error !== 1'b0) begin bad++; $display("FAIL b2b_rberr%0d: got %b want 0", i, readback_error); end
      end
   endtask

   initial begin
      test_reset();
      test_rotate();
      test_count();
      test_disable();
      test_readback();
      test_reset_midwrite();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
